spi_xfer_engine: RTL

Cycle-accurate SPI master (mode 3: CPOL=1, CPHA=1, MSB first) that executes one framed register transaction on the Pmod NAV bus.
A header byte {rw, addr[6:0]} is followed by 1..15 data bytes.
The engine sits directly under the pmod_nav sequencer: the sequencer issues start/rw/addr/len commands and streams bytes through it; this block alone drives cs_n/sclk/mosi to the pins and samples miso.

---
 rtl/spi_xfer_engine.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_engine.sv
// SPI mode-3 master running one framed register transaction: header {rw, addr} then 1..2^LEN_W-1 data bytes.
// All outputs are registered; sclk half-period is CLK_DIV clk cycles, framed by tCSS / hold / CS-high gap.
module spi_xfer_engine #(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             cs_n,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);

  generate
    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
      $error("spi_xfer_engine: CLK_DIV must be in 2..255");
    end
  endgenerate

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [7:0]       div_cnt;
  logic [2:0]       bit_idx;
  logic [LEN_W-1:0] byte_idx;
  logic [LEN_W-1:0] n_lat;
  logic             rw_q;
  logic [6:0]       addr_q;
  logic [7:0]       tx_sh;
  logic [7:0]       rx_sh;
  logic             rx_pend;

  logic             cnt_last;
  logic             fall_evt;
  logic             rise_evt;
  logic             last_bit;

  // SETUP's terminal count produces the first falling edge, so both states share the edge logic.
  assign cnt_last = (div_cnt == DIV_LAST);
  assign fall_evt = cnt_last && ((state == SETUP) || (state == SHIFT && sclk));
  assign rise_evt = cnt_last && (state == SHIFT) && !sclk;
  assign last_bit = (bit_idx == 3'd7) && (byte_idx == n_lat);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !busy)        state_nxt = SETUP;
      SETUP:   if (cnt_last)              state_nxt = SHIFT;
      SHIFT:   if (rise_evt && last_bit)  state_nxt = HOLD;
      HOLD:    if (cnt_last)              state_nxt = GAP;
      GAP:     if (cnt_last)              state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n     <= 1'b1;
      sclk     <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
      rx_pend  <= 1'b0;
      div_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      n_lat    <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
    end else begin
      done     <= 1'b0;
      tx_ready <= 1'b0;
      rx_valid <= rx_pend;
      rx_pend  <= 1'b0;
      if (rx_pend) begin
        rx_data <= rx_sh;
      end
      div_cnt <= (state == IDLE || cnt_last) ? 8'd0 : div_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (start && !busy) begin
            rw_q     <= rw;
            addr_q   <= addr;
            n_lat    <= (len == '0) ? LEN_W'(1) : len;
            busy     <= 1'b1;
            cs_n     <= 1'b0;
            bit_idx  <= '0;
            byte_idx <= '0;
          end
        end

        SETUP, SHIFT: begin
          if (fall_evt) begin
            sclk <= 1'b0;
            if (bit_idx == 3'd0 && byte_idx == '0) begin
              mosi  <= rw_q;
              tx_sh <= {addr_q, 1'b0};
            end else if (bit_idx == 3'd0) begin
              // Data byte boundary: pop the FWFT word on writes, drive zeros on reads.
              if (!rw_q) begin
                mosi     <= tx_data[7];
                tx_sh    <= {tx_data[6:0], 1'b0};
                tx_ready <= 1'b1;
              end else begin
                mosi  <= 1'b0;
                tx_sh <= 8'h00;
              end
            end else begin
              mosi  <= tx_sh[7];
              tx_sh <= {tx_sh[6:0], 1'b0};
            end
          end
          if (rise_evt) begin
            sclk    <= 1'b1;
            rx_sh   <= {rx_sh[6:0], miso};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              if (rw_q && byte_idx != '0) begin
                rx_pend <= 1'b1;
              end
              // Saturates on the last byte so the counter cannot wrap at max length.
              if (byte_idx != n_lat) begin
                byte_idx <= byte_idx + LEN_W'(1);
              end
            end
          end
        end

        HOLD: begin
          if (cnt_last) begin
            cs_n <= 1'b1;
            done <= 1'b1;
            mosi <= 1'b0;
          end
        end

        GAP: begin
          if (cnt_last) begin
            busy <= 1'b0;
          end
        end

        default: ;
      endcase
    end
  end

endmodule
